button_conditioner: RTL and testbench

//  Conditions raw push-button inputs for the multiplier control FSM. Per channel:
//  2-FF synchronizer, counter debounce, one-cycle rise/fall pulses. Drives the

---
 rtl/button_conditioner.sv | 122 ++++++++++++
 tb/tb_button_conditioner.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Push-button conditioner: per channel a 2-FF synchronizer, counter-based
// debounce FSM and registered one-cycle rise/fall pulses.
module button_conditioner #(
  parameter int NUM_BTN    = 3,
  parameter int CNT_MAX    = 50000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_rise,
  output logic [NUM_BTN-1:0] btn_fall
);

  localparam int CW = $clog2(CNT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);
  localparam logic [NUM_BTN-1:0] IDLE_PINS =
    (ACTIVE_LOW != 0) ? {NUM_BTN{1'b1}} : {NUM_BTN{1'b0}};

  if (CNT_MAX < 2) begin : g_cnt_max_check
    $error("button_conditioner: CNT_MAX must be at least 2");
  end

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_CHK,
    PRESSED,
    RELEASE_CHK
  } state_e;

  state_e             state_q [NUM_BTN];
  state_e             state_d [NUM_BTN];
  logic [CW-1:0]      cnt_q   [NUM_BTN];
  logic [CW-1:0]      cnt_d   [NUM_BTN];
  logic [NUM_BTN-1:0] sync1_q, sync1_d;
  logic [NUM_BTN-1:0] sync2_q, sync2_d;
  logic [NUM_BTN-1:0] level_q, level_d;
  logic [NUM_BTN-1:0] rise_q,  rise_d;
  logic [NUM_BTN-1:0] fall_q,  fall_d;
  logic [NUM_BTN-1:0] s;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    s       = sync2_q ^ IDLE_PINS;
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        RELEASED: begin
          if (s[i]) begin
            state_d[i] = PRESS_CHK;
            cnt_d[i]   = '0;
          end
        end
        PRESS_CHK: begin
          if (!s[i]) begin
            state_d[i] = RELEASED;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = PRESSED;
            level_d[i] = 1'b1;
            rise_d[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        PRESSED: begin
          if (!s[i]) begin
            state_d[i] = RELEASE_CHK;
            cnt_d[i]   = '0;
          end
        end
        RELEASE_CHK: begin
          if (s[i]) begin
            state_d[i] = PRESSED;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = RELEASED;
            level_d[i] = 1'b0;
            fall_d[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: state_d[i] = RELEASED;
      endcase
    end
  end

  // Synchronizers reload the released pin value so reset never looks like a press.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q <= IDLE_PINS;
      sync2_q <= IDLE_PINS;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= RELEASED;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign btn_level = level_q;
  assign btn_rise  = rise_q;
  assign btn_fall  = fall_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random bounce traffic,
// checked against a streak-length reference model.
module tb_button_conditioner;

  localparam int NUM_BTN = 3;
  localparam int CNT_MAX = 4;

  logic               Clk;
  logic               Reset;
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_rise;
  logic [NUM_BTN-1:0] btn_fall;

  button_conditioner #(
    .NUM_BTN   (NUM_BTN),
    .CNT_MAX   (CNT_MAX),
    .ACTIVE_LOW(1)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .btn_rise (btn_rise),
    .btn_fall (btn_fall)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: a change is accepted once the two-edge-delayed pressed sample has
  // differed from the accepted level for CNT_MAX+1 consecutive edges.
  logic [NUM_BTN-1:0] hist [$];
  int                 streak [NUM_BTN];
  logic [NUM_BTN-1:0] lvl_m, rise_m, fall_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_edge(input logic [NUM_BTN-1:0] raw, input logic rst);
    logic [NUM_BTN-1:0] pressed;
    rise_m = '0;
    fall_m = '0;
    if (rst) begin
      hist = '{{NUM_BTN{1'b1}}, {NUM_BTN{1'b1}}};
      lvl_m = '0;
      for (int c = 0; c < NUM_BTN; c++) streak[c] = 0;
    end else begin
      pressed = ~hist[0];
      void'(hist.pop_front());
      hist.push_back(raw);
      for (int c = 0; c < NUM_BTN; c++) begin
        if (pressed[c] != lvl_m[c]) streak[c]++;
        else streak[c] = 0;
        if (streak[c] == CNT_MAX + 1) begin
          lvl_m[c] = pressed[c];
          if (pressed[c]) rise_m[c] = 1'b1;
          else fall_m[c] = 1'b1;
          streak[c] = 0;
        end
      end
    end
  endtask

  task automatic step(input logic [NUM_BTN-1:0] raw, input logic rst);
    btn_raw = raw;
    Reset   = rst;
    @(posedge Clk);
    model_edge(raw, rst);
    #1;
    check("model_level", 32'(btn_level), 32'(lvl_m));
    check("model_rise",  32'(btn_rise),  32'(rise_m));
    check("model_fall",  32'(btn_fall),  32'(fall_m));
    check("rise_fall_excl", 32'(btn_rise & btn_fall), 32'd0);
  endtask

  initial begin
    int rise_cnt;
    int fall_cnt;
    logic [NUM_BTN-1:0] raw_r;
    int hold [NUM_BTN];

    Reset   = 1'b1;
    btn_raw = '1;
    hist    = '{{NUM_BTN{1'b1}}, {NUM_BTN{1'b1}}};
    lvl_m   = '0;
    for (int c = 0; c < NUM_BTN; c++) streak[c] = 0;

    // 1: reset, all released
    step(3'b111, 1'b1);
    step(3'b111, 1'b1);
    check("t1_reset_level", 32'(btn_level), 32'd0);
    check("t1_reset_rise",  32'(btn_rise),  32'd0);
    for (int i = 0; i < 20; i++) begin
      step(3'b111, 1'b0);
      check("t1_level", 32'(btn_level), 32'd0);
      check("t1_pulses", 32'(btn_rise | btn_fall), 32'd0);
    end

    // 2: press channel 0 at e0, hold
    for (int i = 0; i < 8; i++) begin
      step(3'b110, 1'b0);
      check("t2_rise0",  32'(btn_rise[0]),  32'(i == 6));
      check("t2_level0", 32'(btn_level[0]), 32'(i >= 6));
    end

    // 3: channel 1 bounces every 2 cycles, then held low
    rise_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step({1'b1, ((i / 2) % 2 == 1), 1'b0}, 1'b0);
      rise_cnt += int'(btn_rise[1]);
    end
    check("t3_bounce_rises", 32'(rise_cnt), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step(3'b100, 1'b0);
      rise_cnt += int'(btn_rise[1]);
      check("t3_rise1", 32'(btn_rise[1]), 32'(i == 6));
    end
    check("t3_total_rises", 32'(rise_cnt), 32'd1);

    // 4: release channel 0 at e0
    for (int i = 0; i < 8; i++) begin
      step(3'b101, 1'b0);
      check("t4_fall0",  32'(btn_fall[0]),  32'(i == 6));
      check("t4_level0", 32'(btn_level[0]), 32'(i < 6));
    end

    // 5: press channel 0 again, then a 2-cycle release glitch
    for (int i = 0; i < 8; i++) step(3'b100, 1'b0);
    check("t5_pressed", 32'(btn_level[0]), 32'd1);
    fall_cnt = 0;
    step(3'b101, 1'b0);
    step(3'b101, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(3'b100, 1'b0);
      fall_cnt += int'(btn_fall[0]);
      check("t5_level0", 32'(btn_level[0]), 32'd1);
    end
    check("t5_no_fall", 32'(fall_cnt), 32'd0);

    // 6: press channels 0 and 2 together, reset at e3, then recount
    for (int i = 0; i < 10; i++) step(3'b111, 1'b0);
    check("t6_released", 32'(btn_level), 32'd0);
    step(3'b010, 1'b0);
    step(3'b010, 1'b0);
    step(3'b010, 1'b0);
    step(3'b010, 1'b1);
    check("t6_rst_level", 32'(btn_level), 32'd0);
    check("t6_rst_rise",  32'(btn_rise),  32'd0);
    check("t6_rst_fall",  32'(btn_fall),  32'd0);
    for (int i = 0; i < 8; i++) begin
      step(3'b010, 1'b0);
      check("t6_rise",  32'(btn_rise),  (i == 6) ? 32'h5 : 32'h0);
      check("t6_level", 32'(btn_level), (i >= 6) ? 32'h5 : 32'h0);
    end

    // Random bounce traffic with occasional resets
    for (int c = 0; c < NUM_BTN; c++) hold[c] = 0;
    raw_r = '1;
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < NUM_BTN; c++) begin
        if (hold[c] == 0) begin
          raw_r[c] = 1'($urandom_range(0, 1));
          hold[c]  = int'($urandom_range(1, 8));
        end
        hold[c]--;
      end
      step(raw_r, ($urandom_range(0, 99) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
